psum_accumulator: RTL

- Sits directly downstream of the CIM Macro and consumes its 8-lane × 14b PSUM bus.
- Accumulates partial sums over multiple macro passes, for input channels > 64 or multi-row-group tiles, into 8 wide accumulators.
- Presents each finished group on a valid/ready output holding register so the next group can start while the result drains.

---
 rtl/psum_accumulator_if.sv | 32 +++
 rtl/psum_accumulator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator_if.sv
// Bundle between the CIM macro PSUM stream, the accumulator and its result consumer.
// Both the psum beat channel and the acc result channel use one rule:
// a transfer happens on a rising edge where valid && ready are both high.
// The sender holds its payload and valid until that edge, and ready may depend on valid.
interface psum_accumulator_if #(
  parameter int LANES  = 8,
  parameter int PSUM_W = 14,
  parameter int ACC_W  = 20,
  parameter int CNT_W  = 7
) ();
  logic [LANES*PSUM_W-1:0] psum_in;
  logic                    psum_valid;
  logic                    psum_first;
  logic                    psum_last;
  logic                    psum_ready;
  logic [LANES*ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]        acc_count;
  logic                    acc_ovf;
  logic                    acc_valid;
  logic                    acc_ready;

  // master: macro-side producer plus result consumer; slave: the accumulator
  modport master (
    output psum_in, psum_valid, psum_first, psum_last, acc_ready,
    input  psum_ready, acc_out, acc_count, acc_ovf, acc_valid
  );

  modport slave (
    input  psum_in, psum_valid, psum_first, psum_last, acc_ready,
    output psum_ready, acc_out, acc_count, acc_ovf, acc_valid
  );
endinterface

// File: rtl/psum_accumulator.sv
// Multi-pass partial-sum accumulator behind the CIM macro, with a valid/ready result register.
// Optional macro PSUM_SAT_EN: lanes clamp at all-ones on overflow instead of wrapping.
module psum_accumulator #(
  parameter int LANES  = 8,
  parameter int PSUM_W = 14,
  parameter int ACC_W  = 20,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  psum_accumulator_if.slave bus,
  output logic              proto_err,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0] acc_q     [LANES];
  logic [ACC_W-1:0] lane_base [LANES];
  logic [ACC_W:0]   wide_sum  [LANES];
  logic [ACC_W-1:0] lane_sum  [LANES];
  logic [LANES-1:0] lane_carry;
  logic [LANES*ACC_W-1:0] sum_flat;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_full;
  logic             grp_ovf_q;
  logic             grp_ovf_sum;

  logic [LANES*ACC_W-1:0] out_q;
  logic [CNT_W-1:0]       out_cnt_q;
  logic                   out_ovf_q;
  logic                   out_valid_q;
  logic                   proto_err_q;

  logic psum_ready;
  logic accept;
  logic restart;
  logic emit;
  logic load_grp;
  logic err_beat;

  assign psum_ready = !out_valid_q || bus.acc_ready;
  assign accept     = bus.psum_valid && psum_ready;
  // A beat in IDLE always opens a group, even if psum_first was not raised
  assign restart    = bus.psum_first || (state_q == IDLE);

  always_comb begin : lane_math
    lane_carry = '0;
    sum_flat   = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_base[k]  = restart ? '0 : acc_q[k];
      wide_sum[k]   = {1'b0, lane_base[k]} +
                      {{(ACC_W + 1 - PSUM_W){1'b0}}, bus.psum_in[k*PSUM_W +: PSUM_W]};
      lane_carry[k] = wide_sum[k][ACC_W];
`ifdef PSUM_SAT_EN
      // A clamped lane only ever adds non-negative values, so it stays clamped
      lane_sum[k]   = lane_carry[k] ? '1 : wide_sum[k][ACC_W-1:0];
`else
      lane_sum[k]   = wide_sum[k][ACC_W-1:0];
`endif
      sum_flat[k*ACC_W +: ACC_W] = lane_sum[k];
    end
  end

  always_comb begin : group_math
    grp_ovf_sum = (restart ? 1'b0 : grp_ovf_q) | (|lane_carry);
    cnt_base    = restart ? '0 : cnt_q;
    cnt_full    = (cnt_base == {CNT_W{1'b1}});
    cnt_next    = cnt_full ? cnt_base : cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    emit     = 1'b0;
    load_grp = 1'b0;
    err_beat = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE:    err_beat = !bus.psum_first || cnt_full;
        ACCUM:   err_beat = bus.psum_first || cnt_full;
        default: err_beat = 1'b0;
      endcase
      if (bus.psum_last) begin
        emit    = 1'b1;
        state_d = IDLE;
      end else begin
        load_grp = 1'b1;
        state_d  = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : group_regs
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= '0;
      end
      cnt_q     <= '0;
      grp_ovf_q <= 1'b0;
    end else if (emit) begin
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= '0;
      end
      cnt_q     <= '0;
      grp_ovf_q <= 1'b0;
    end else if (load_grp) begin
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= lane_sum[k];
      end
      cnt_q     <= cnt_next;
      grp_ovf_q <= grp_ovf_sum;
    end
  end

  // Result register: an emit on the same edge as a consumer take simply reloads it
  always_ff @(posedge clk or negedge rst_n) begin : out_regs
    if (!rst_n) begin
      out_q       <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (emit) begin
      out_q       <= sum_flat;
      out_cnt_q   <= cnt_next;
      out_ovf_q   <= grp_ovf_sum;
      out_valid_q <= 1'b1;
    end else if (bus.acc_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : err_reg
    if (!rst_n) begin
      proto_err_q <= 1'b0;
    end else if (err_beat) begin
      proto_err_q <= 1'b1;
    end
  end

  assign bus.psum_ready = psum_ready;
  assign bus.acc_out    = out_q;
  assign bus.acc_count  = out_cnt_q;
  assign bus.acc_ovf    = out_ovf_q;
  assign bus.acc_valid  = out_valid_q;
  assign proto_err      = proto_err_q;
  assign busy           = (state_q == ACCUM);

  ap_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.acc_ready) |=> (out_valid_q && $stable(out_q) && $stable(out_cnt_q)));

endmodule
